// File: rtl/led_sched_pkg.sv
// Shared definitions for the LED bar scheduler.
//   state_t      : scheduler state (power-on sweep, velocity bar, alert blink)
//   LED_W/CODE_W : LED bar width and alert code width
//   LED_OFF      : all LEDs dark
//   code_pattern : alert code replicated across the whole bar
package led_sched_pkg;

  localparam int unsigned LED_W  = 16;
  localparam int unsigned CODE_W = 4;

  localparam logic [LED_W-1:0] LED_OFF   = '0;
  localparam logic [LED_W-1:0] LED_FIRST = 16'h0001;

  typedef enum logic [1:0] {
    SWEEP,
    BAR,
    ALERT
  } state_t;

  function automatic logic [LED_W-1:0] code_pattern(input logic [CODE_W-1:0] c);
    return {(LED_W / CODE_W){c}};
  endfunction

endpackage

// File: rtl/led_display_sched_tick_gen.sv
// Animation tick prescaler.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   clr  : synchronous restart of the count at zero
//   tick : high for one cycle while the count sits at TICK_DIV-1
module tick_gen #(
  parameter int unsigned TICK_DIV = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/led_display_sched.sv
// LED bar scheduler: power-on sweep, then the velocity bar, interrupted by
// blinking alert codes. Alert requests that cannot be shown immediately are
// held in a one-deep buffer (latest request wins).
//   clk        : system clock
//   rst        : synchronous active-high reset
//   bar_led    : velocity bar pattern, captured on bar_valid
//   bar_valid  : single-cycle qualifier for bar_led
//   alert_req  : alert request pulse
//   alert_code : alert code sampled with alert_req
//   alert_ack  : one-cycle pulse when a request enters ALERT
//   alert_ovf  : one-cycle pulse when a buffered request is overwritten
//   busy       : high whenever the scheduler is not showing the bar
//   led_out    : registered LED drive
module led_display_sched
  import led_sched_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 5_000_000,
  parameter int unsigned ALERT_BLINKS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LED_W-1:0]  bar_led,
  input  logic              bar_valid,
  input  logic              alert_req,
  input  logic [CODE_W-1:0] alert_code,
  output logic              alert_ack,
  output logic              alert_ovf,
  output logic              busy,
  output logic [LED_W-1:0]  led_out
);

  localparam int unsigned NPHASE = 2 * ALERT_BLINKS;
  localparam int unsigned BW     = (NPHASE > 1) ? $clog2(NPHASE) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(NPHASE - 1);
  localparam logic [3:0]    STEP_LAST  = 4'd15;

  state_t              state;
  state_t              nxt;
  logic [3:0]          step;
  logic [BW-1:0]       blink_cnt;
  logic                phase;
  logic [CODE_W-1:0]   code;
  logic [LED_W-1:0]    bar_reg;
  logic                pending;
  logic [CODE_W-1:0]   pend_code;

  logic tick;
  logic enter;       // entering ALERT this cycle (fresh or chained)
  logic consume;     // entry takes its code from the buffer
  logic direct;      // entry takes its code straight from alert_req
  logic buffer_req;  // request that must wait in the buffer
  logic ovf_now;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (enter),
    .tick(tick)
  );

  always_comb begin
    nxt     = state;
    enter   = 1'b0;
    consume = 1'b0;
    case (state)
      SWEEP: begin
        if (tick && step == STEP_LAST) begin
          if (pending) begin
            nxt     = ALERT;
            enter   = 1'b1;
            consume = 1'b1;
          end else begin
            nxt = BAR;
          end
        end
      end
      BAR: begin
        if (pending) begin
          nxt     = ALERT;
          enter   = 1'b1;
          consume = 1'b1;
        end else if (alert_req) begin
          nxt   = ALERT;
          enter = 1'b1;
        end
      end
      ALERT: begin
        if (tick && blink_cnt == BLINK_LAST) begin
          if (pending) begin
            nxt     = ALERT;
            enter   = 1'b1;
            consume = 1'b1;
          end else begin
            nxt = BAR;
          end
        end
      end
      default: nxt = SWEEP;
    endcase
  end

  // A request is shown directly only from BAR with an empty buffer; every
  // other request lands in the buffer, including one arriving while the
  // buffer is being drained this same cycle (that case is not an overwrite).
  assign direct     = (state == BAR) && !pending && alert_req;
  assign buffer_req = alert_req && !direct;
  assign ovf_now    = buffer_req && pending && !consume;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SWEEP;
      step      <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      code      <= '0;
      bar_reg   <= '0;
      pending   <= 1'b0;
      pend_code <= '0;
      led_out   <= LED_OFF;
      alert_ack <= 1'b0;
      alert_ovf <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state     <= nxt;
      busy      <= (nxt != BAR);
      alert_ack <= enter;
      alert_ovf <= ovf_now;

      if (bar_valid) begin
        bar_reg <= bar_led;
      end

      if (buffer_req) begin
        pending   <= 1'b1;
        pend_code <= alert_code;
      end else if (consume) begin
        pending <= 1'b0;
      end

      case (state)
        SWEEP: begin
          led_out <= LED_FIRST << step;
          if (tick) begin
            step <= step + 4'd1;
          end
        end
        BAR: begin
          led_out <= bar_reg;
        end
        ALERT: begin
          led_out <= phase ? code_pattern(code) : LED_OFF;
          if (tick) begin
            phase     <= ~phase;
            blink_cnt <= blink_cnt + BW'(1);
          end
        end
        default: led_out <= LED_OFF;
      endcase

      // Entry setup must win over the tick update of a finishing alert.
      if (enter) begin
        code      <= consume ? pend_code : alert_code;
        phase     <= 1'b1;
        blink_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_led_display_sched.sv
// Self-checking bench for led_display_sched (TICK_DIV=4, ALERT_BLINKS=2).
// The reference model tracks the displayed mode and the cycles spent in it,
// deriving the LED image from elapsed time.
module tb_led_display_sched;

  localparam int TD = 4;
  localparam int AB = 2;
  localparam int M_SWEEP = 0;
  localparam int M_BAR   = 1;
  localparam int M_ALERT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bar_led = '0;
  logic        bar_valid = 1'b0;
  logic        alert_req = 1'b0;
  logic [3:0]  alert_code = '0;
  logic        alert_ack;
  logic        alert_ovf;
  logic        busy;
  logic [15:0] led_out;

  int errors = 0;
  int checks = 0;
  int ack_seen = 0;
  int seen5555 = 0;

  int          m_mode = M_SWEEP;
  int          m_el = 0;
  logic [15:0] m_bar = '0;
  bit          m_pend = 1'b0;
  logic [3:0]  m_pcode = '0;
  logic [3:0]  m_code = '0;
  logic [15:0] e_led = '0;
  logic        e_busy = 1'b1;
  logic        e_ack = 1'b0;
  logic        e_ovf = 1'b0;

  led_display_sched #(
    .TICK_DIV(TD),
    .ALERT_BLINKS(AB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bar_led(bar_led),
    .bar_valid(bar_valid),
    .alert_req(alert_req),
    .alert_code(alert_code),
    .alert_ack(alert_ack),
    .alert_ovf(alert_ovf),
    .busy(busy),
    .led_out(led_out)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    bit         done;
    bit         enter;
    bit         consume;
    bit         direct;
    logic [3:0] ncode;
    if (rst) begin
      m_mode = M_SWEEP; m_el = 0; m_bar = '0; m_pend = 1'b0;
      m_pcode = '0; m_code = '0;
      e_led = '0; e_busy = 1'b1; e_ack = 1'b0; e_ovf = 1'b0;
    end else begin
      case (m_mode)
        M_SWEEP: e_led = 16'(1) << (m_el / TD);
        M_BAR:   e_led = m_bar;
        default: e_led = ((m_el / TD) % 2 == 0) ? {4{m_code}} : 16'h0000;
      endcase
      done = (m_mode == M_SWEEP && m_el == 16 * TD - 1) ||
             (m_mode == M_ALERT && m_el == 2 * AB * TD - 1);
      enter = 1'b0; consume = 1'b0; ncode = m_code;
      direct = (m_mode == M_BAR) && !m_pend && alert_req;
      if ((done || m_mode == M_BAR) && m_pend) begin
        enter = 1'b1; consume = 1'b1; ncode = m_pcode;
      end else if (direct) begin
        enter = 1'b1; ncode = alert_code;
      end
      e_ovf = 1'b0;
      if (alert_req && !direct) begin
        e_ovf = m_pend && !consume;
        m_pend = 1'b1;
        m_pcode = alert_code;
      end else if (consume) begin
        m_pend = 1'b0;
      end
      e_ack = enter;
      if (enter) begin
        m_mode = M_ALERT; m_code = ncode; m_el = 0;
      end else if (done) begin
        m_mode = M_BAR; m_el = 0;
      end else begin
        m_el++;
      end
      e_busy = (m_mode != M_BAR);
      if (bar_valid) m_bar = bar_led;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("led_out", led_out, e_led);
    chk("busy", 16'(busy), 16'(e_busy));
    chk("alert_ack", 16'(alert_ack), 16'(e_ack));
    chk("alert_ovf", 16'(alert_ovf), 16'(e_ovf));
    if (alert_ack === 1'b1) ack_seen++;
    if (led_out === 16'h5555) seen5555++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic req(input logic [3:0] c);
    alert_code = c;
    alert_req = 1'b1;
    cycle();
    alert_req = 1'b0;
  endtask

  initial begin
    // Reset release and power-on sweep
    rst = 1'b1;
    run(2);
    chk("reset_led", led_out, 16'h0000);
    chk("reset_busy", 16'(busy), 16'h0001);
    rst = 1'b0;
    cycle();
    chk("sweep_first", led_out, 16'h0001);
    run(3);
    chk("sweep_hold", led_out, 16'h0001);
    cycle();
    chk("sweep_shift", led_out, 16'h0002);
    run(59);
    chk("sweep_last", led_out, 16'h8000);
    chk("sweep_done_busy", 16'(busy), 16'h0000);
    cycle();
    chk("bar_cleared", led_out, 16'h0000);

    // Bar path
    bar_led = 16'h00FF; bar_valid = 1'b1;
    cycle();
    bar_valid = 1'b0; bar_led = 16'h0F00;
    cycle();
    chk("bar_latency", led_out, 16'h00FF);
    run(3);
    chk("bar_hold", led_out, 16'h00FF);

    // Direct alert
    req(4'hA);
    chk("direct_ack", 16'(alert_ack), 16'h0001);
    cycle();
    chk("direct_on", led_out, 16'hAAAA);
    run(14);
    chk("direct_busy_end", 16'(busy), 16'h0001);
    cycle();
    chk("direct_busy_drop", 16'(busy), 16'h0000);
    chk("direct_last_off", led_out, 16'h0000);
    cycle();
    chk("direct_back_bar", led_out, 16'h00FF);

    // Request buffered during the sweep
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(10);
    req(4'h3);
    ack_seen = 0;
    run(52);
    chk("sweep_no_ack", 16'(ack_seen), 16'h0000);
    cycle();
    chk("sweep_exit_ack", 16'(alert_ack), 16'h0001);
    chk("sweep_exit_busy", 16'(busy), 16'h0001);
    cycle();
    chk("sweep_exit_alert", led_out, 16'h3333);
    run(16);

    // Overflow: 5 is overwritten by 6
    bar_led = 16'h00FF; bar_valid = 1'b1;
    cycle();
    bar_valid = 1'b0;
    run(2);
    seen5555 = 0;
    req(4'hA);
    run(2);
    req(4'h5);
    run(2);
    req(4'h6);
    chk("ovf_pulse", 16'(alert_ovf), 16'h0001);
    run(40);
    chk("ovf_no_5555", 16'(seen5555), 16'h0000);

    // Reset in the middle of an alert with a request pending
    req(4'hA);
    run(2);
    req(4'h9);
    run(2);
    rst = 1'b1;
    cycle();
    chk("midrst_led", led_out, 16'h0000);
    chk("midrst_busy", 16'(busy), 16'h0001);
    rst = 1'b0;
    cycle();
    chk("midrst_restart", led_out, 16'h0001);
    ack_seen = 0;
    run(70);
    chk("midrst_no_ack", 16'(ack_seen), 16'h0000);

    // Randomized traffic
    for (int i = 0; i < 700; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      bar_valid  = ($urandom_range(0, 3) == 0);
      bar_led    = 16'($urandom);
      alert_req  = ($urandom_range(0, 9) == 0);
      alert_code = 4'($urandom);
      cycle();
    end
    rst = 1'b0; bar_valid = 1'b0; alert_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
